// File: rtl/divider_16.sv
// Sequential unsigned 16-bit restoring divider, one shift-subtract step per clock.
// Each trial subtraction runs through a ripple adder_16 (inverted divisor, carry-in 1).

module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 16; gi++) begin : g_ripple
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[16];

endmodule

module divider_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  // The partial remainder's 17th bit is always zero after a step, so only 16 bits are kept.
  logic [15:0] r_reg;
  logic [15:0] q_reg;
  logic [15:0] d_reg;
  logic [3:0]  count_reg;

  logic [16:0] s;
  logic [15:0] t;
  logic        c;
  logic        no_borrow;
  logic [15:0] r_next;
  logic [15:0] q_next;

  assign s = {r_reg, q_reg[15]};

  adder_16 u_sub (
    .a    (s[15:0]),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (t),
    .cout (c)
  );

  assign no_borrow = s[16] | c;
  assign r_next    = no_borrow ? t : s[15:0];
  assign q_next    = {q_reg[14:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == 16'd0) begin
              quotient    <= 16'hFFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_reg   <= DONE;
            end else begin
              r_reg     <= '0;
              q_reg     <= dividend;
              d_reg     <= divisor;
              count_reg <= '0;
              busy      <= 1'b1;
              state_reg <= RUN;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          r_reg     <= r_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            state_reg   <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16.sv
// Directed bench for divider_16: latency, results, divide-by-zero, ignored start,
// back-to-back operation and asynchronous reset abort.

module tb_divider_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;

  divider_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Called right after start has been driven at a falling edge (cycle T); k counts cycles after T.
  task automatic collect(input string tag, input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int elat,
                         input logic chain, input logic [15:0] na, input logic [15:0] nb,
                         input logic inj, input logic chk_hold, input logic [15:0] hold_q);
    int lat = 0;
    int nbusy = 0;
    int overlap = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (inj && k == 5) launch(16'd50, 16'd5);
      if (inj && k == 6) start = 1'b0;
      if (chk_hold && k == 8) check({tag, "_hold_q"}, {16'd0, quotient}, {16'd0, hold_q});
      if (busy && done) overlap++;
      if (done) begin
        lat = k;
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        if (chain) launch(na, nb);
      end else if (busy) begin
        nbusy++;
      end
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, nbusy, elat - 1);
    check({tag, "_busy_done_overlap"}, overlap, 0);
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eq, input logic [15:0] er, input logic ez, input int elat);
    @(negedge clk);
    launch(a, b);
    collect(tag, eq, er, ez, elat, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    int ndone;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_q", {16'd0, quotient}, 0);
    check("rst_r", {16'd0, remainder}, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);
    rst_n = 1'b1;

    op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    op("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 17);
    op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17);
    op("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
    op("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);

    // Second start during RUN must be dropped without touching the latched operands.
    @(negedge clk);
    launch(16'd100, 16'd7);
    collect("ignore", 16'd14, 16'd2, 1'b0, 17, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_extra_done", ndone, 0);
    check("ignore_idle_hold_q", {16'd0, quotient}, 14);

    @(negedge clk);
    launch(16'd1000, 16'd33);
    collect("b2b_first", 16'd30, 16'd10, 1'b0, 17, 1'b1, 16'h8000, 16'd3, 1'b0, 1'b0, 16'd0);
    collect("b2b_second", 16'h2AAA, 16'd2, 1'b0, 17, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd30);

    // Reset in the middle of a run clears outputs at once and produces no done.
    @(negedge clk);
    launch(16'd100, 16'd7);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_q", {16'd0, quotient}, 0);
    check("abort_r", {16'd0, remainder}, 0);
    check("abort_dbz", {31'd0, div_by_zero}, 0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_quiet", ndone, 0);
    rst_n = 1'b1;
    launch(16'd9, 16'd4);
    collect("after_rst_9_4", 16'd2, 16'd1, 1'b0, 17, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
